dac_spi_scheduler: RTL

DAC_SPI_SCHEDULER -- requirements
Module: dac_spi_scheduler

---
 rtl/dac_spi_scheduler.sv | 135 +++++++++++++
 1 files changed

// File: rtl/dac_spi_scheduler.sv
// Serial DAC front end: reset pulse, table-driven init sequence, then round-robin
// host writes, each frame followed by a gap and an LDAC strobe.
module dac_spi_scheduler #(
  parameter int WORD_W  = 24,
  parameter int DIV     = 4,
  parameter int RST_LEN = 16,
  parameter int N_INIT  = 8
) (
  input  logic              sys_clk,
  input  logic              rst,
  input  logic              req_a,
  input  logic              req_b,
  input  logic [WORD_W-1:0] data_a,
  input  logic [WORD_W-1:0] data_b,
  output logic              ack_a,
  output logic              ack_b,
  output logic [3:0]        init_addr,
  input  logic [WORD_W-1:0] init_data,
  output logic              sclk,
  output logic              sdi,
  output logic              n_sync,
  output logic              n_reset,
  output logic              n_ldac,
  output logic              busy,
  output logic              init_done
);

  typedef enum logic [2:0] {RST_PULSE, LOAD, FRAME, GAP, LDAC, IDLE} state_t;

  localparam int              CW       = 16;
  localparam int              PW       = $clog2(2 * WORD_W + 1);
  localparam logic [PW-1:0]   LAST_PH  = PW'(2 * WORD_W);
  localparam logic [3:0]      LAST_IDX = 4'(N_INIT - 1);

  state_t            state, state_n;
  logic [CW-1:0]     cnt, cnt_lim;
  logic              cnt_done;
  logic [PW-1:0]     ph;
  logic [WORD_W-1:0] shreg;
  logic [3:0]        idx;
  logic              last_b;
  logic              grant_a, grant_b;

  // Phase 0 is the sclk-high setup; odd phases are sclk low, even phases high.
  always_comb begin
    cnt_lim = CW'(1);
    case (state)
      RST_PULSE:  cnt_lim = CW'(RST_LEN);
      FRAME, GAP: cnt_lim = CW'(DIV);
      LDAC:       cnt_lim = CW'(2 * DIV);
      default:    cnt_lim = CW'(1);
    endcase
  end

  assign cnt_done = (cnt == cnt_lim - CW'(1));

  always_ff @(posedge sys_clk) begin
    // NOTE: registers take non-blocking assignments so every flop samples pre-edge values.
    if (rst) state <= RST_PULSE;
    else     state <= state_n;
  end

  always_comb begin
    // NOTE: defaults first so no path leaves a variable unassigned (no latches).
    state_n = state;
    grant_a = 1'b0;
    grant_b = 1'b0;
    case (state)
      RST_PULSE: if (cnt_done) state_n = LOAD;
      LOAD:      state_n = FRAME;
      FRAME:     if (cnt_done && ph == LAST_PH) state_n = GAP;
      GAP: begin
        if (cnt_done) begin
          if (!init_done && idx < LAST_IDX) state_n = LOAD;
          else                              state_n = LDAC;
        end
      end
      LDAC:      if (cnt_done) state_n = IDLE;
      IDLE: begin
        if (req_a && (!req_b || last_b)) grant_a = 1'b1;
        else if (req_b)                  grant_b = 1'b1;
        if (grant_a || grant_b) state_n = FRAME;
      end
      default:   state_n = RST_PULSE;
    endcase
    if (rst) begin
      state_n = RST_PULSE;
      grant_a = 1'b0;
      grant_b = 1'b0;
    end
  end

  always_ff @(posedge sys_clk) begin
    if (rst) begin
      cnt       <= '0;
      ph        <= '0;
      idx       <= '0;
      shreg     <= '0;
      last_b    <= 1'b1;
      init_done <= 1'b0;
    end else begin
      if (state_n != state || cnt_done) cnt <= '0;
      else                              cnt <= cnt + CW'(1);

      if (state != FRAME)  ph <= '0;
      else if (cnt_done)   ph <= (ph == LAST_PH) ? '0 : ph + PW'(1);

      // The end of every odd (low) phase is a rising sclk edge: present the next bit.
      if (state == LOAD)                          shreg <= init_data;
      else if (grant_a)                           shreg <= data_a;
      else if (grant_b)                           shreg <= data_b;
      else if (state == FRAME && cnt_done && ph[0]) shreg <= {shreg[WORD_W-2:0], 1'b0};

      if (state == GAP && cnt_done && !init_done && idx < LAST_IDX) idx <= idx + 4'd1;

      if (grant_a) last_b <= 1'b0;
      if (grant_b) last_b <= 1'b1;

      if (state == LDAC && cnt_done) init_done <= 1'b1;
    end
  end

  always_comb begin
    ack_a     = grant_a;
    ack_b     = grant_b;
    init_addr = idx;
    sclk      = !(state == FRAME && ph[0]);
    sdi       = (state == FRAME) ? shreg[WORD_W-1] : 1'b0;
    n_sync    = (state != FRAME);
    n_reset   = (state != RST_PULSE);
    n_ldac    = (state != LDAC);
    busy      = (state != IDLE);
  end

endmodule
